// File: rtl/mimo_frame_sched.sv
// -----------------------------------------------------------------------------
// mimo_frame_sched
//
// Frame-level sequencer for a MIMO detector datapath. Each accepted H/Y frame
// is walked through three phases:
//   DEC : QR decomposition runs for DEC_LAT cycles (dec_start on first cycle)
//   PG  : path generator runs for PG_LAT cycles    (pg_start on first cycle)
//   OUT : PATH/PED result is offered on out_valid until out_ready
// A new frame may be accepted in the same cycle as the OUT handshake, so a
// continuous stream is processed with one frame every DEC_LAT+PG_LAT+1 cycles.
//
// Parameters
//   DEC_LAT  decomposition latency in cycles (1..63)
//   PG_LAT   path generator latency in cycles (1..63)
//   ID_W     width of the frame tag
//
// Optional feature (compile-time macro FRAME_CNT_EN)
//   defined   : frame_cnt counts completed frames, saturating at 16'hFFFF
//   undefined : frame_cnt is tied to zero and no counter register exists
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous reset, active low
//   in_valid   in   H/Y frame present
//   in_ready   out  frame accepted when in_valid is also high (combinational)
//   ld_en      out  H/Y input-register capture strobe (in_valid & in_ready)
//   dec_start  out  decomposition start pulse
//   pg_start   out  path generator start pulse
//   out_valid  out  PATH/PED result ready
//   out_ready  in   downstream accepts the result
//   flush      in   synchronous abort, highest priority
//   frame_id   out  tag of the current frame
//   busy       out  scheduler not idle
//   frame_cnt  out  count of completed frames
// -----------------------------------------------------------------------------
module mimo_frame_sched #(
    parameter int DEC_LAT = 6,
    parameter int PG_LAT  = 4,
    parameter int ID_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            ld_en,
    output logic            dec_start,
    output logic            pg_start,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            flush,
    output logic [ID_W-1:0] frame_id,
    output logic            busy,
    output logic [15:0]     frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEC  = 2'd1,
        ST_PG   = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // The phase counter counts down to zero, so it is loaded with LAT-1.
    localparam logic [5:0] DEC_LOAD = 6'(DEC_LAT - 1);
    localparam logic [5:0] PG_LOAD  = 6'(PG_LAT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [5:0]      r_cnt;
    logic [5:0]      w_cnt_nxt;
    logic            r_dec_start;
    logic            r_pg_start;
    logic            r_out_valid;
    logic            r_busy;
    logic [ID_W-1:0] r_frame_id;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_out_hs;

    // Input-side handshake: open in IDLE, and in OUT only when the result
    // leaves in the same cycle; reset and flush both close it.
    always_comb begin
        w_in_ready = 1'b0;
        if (!rst || flush) begin
            w_in_ready = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: w_in_ready = 1'b1;
                ST_OUT:  w_in_ready = out_ready;
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    assign w_accept = in_valid & w_in_ready;
    // A result handshake is never honoured while flushing.
    assign w_out_hs = (r_state == ST_OUT) & out_ready & ~flush;

    // Next-state and phase-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = ST_DEC;
                        w_cnt_nxt   = DEC_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 6'd0;
                    end
                end
                ST_DEC: begin
                    if (r_cnt == 6'd0) begin
                        w_state_nxt = ST_PG;
                        w_cnt_nxt   = PG_LOAD;
                    end else begin
                        w_state_nxt = ST_DEC;
                        w_cnt_nxt   = r_cnt - 6'd1;
                    end
                end
                ST_PG: begin
                    if (r_cnt == 6'd0) begin
                        w_state_nxt = ST_OUT;
                        w_cnt_nxt   = 6'd0;
                    end else begin
                        w_state_nxt = ST_PG;
                        w_cnt_nxt   = r_cnt - 6'd1;
                    end
                end
                ST_OUT: begin
                    if (w_out_hs) begin
                        // Overlapped accept goes straight back into DEC.
                        if (w_accept) begin
                            w_state_nxt = ST_DEC;
                            w_cnt_nxt   = DEC_LOAD;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = 6'd0;
                        end
                    end else begin
                        w_state_nxt = ST_OUT;
                        w_cnt_nxt   = 6'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 6'd0;
                end
            endcase
        end
    end

    // State, counter and registered strobes. Strobes are decoded from the
    // upcoming transition so they are high exactly in the first cycle of a
    // phase and come straight from flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 6'd0;
            r_dec_start <= 1'b0;
            r_pg_start  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dec_start <= (w_state_nxt == ST_DEC) && (r_state != ST_DEC);
            r_pg_start  <= (w_state_nxt == ST_PG) && (r_state == ST_DEC);
            r_out_valid <= (w_state_nxt == ST_OUT);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Frame tag: advances on every accept and wraps naturally; flush leaves it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_id <= {ID_W{1'b0}};
        end else if (w_accept) begin
            r_frame_id <= r_frame_id + ID_W'(1);
        end else begin
            r_frame_id <= r_frame_id;
        end
    end

`ifdef FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Completed-frame counter, saturating so it never wraps back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= 16'd0;
        end else if (w_out_hs && (r_frame_cnt != 16'hFFFF)) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
            r_frame_cnt <= r_frame_cnt;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 16'd0;
`endif

    assign in_ready  = w_in_ready;
    assign ld_en     = w_accept;
    assign dec_start = r_dec_start;
    assign pg_start  = r_pg_start;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign frame_id  = r_frame_id;

endmodule

// File: tb/tb_mimo_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_mimo_frame_sched
// Directed stimulus with a cycle-level model of the scheduler expressed as
// "cycles elapsed since the frame was accepted", checked every cycle, plus
// hand-computed literal latencies/tags that pin the model itself.
// -----------------------------------------------------------------------------
module tb_mimo_frame_sched;

    localparam int DL = 6;
    localparam int PL = 4;
    localparam int IW = 8;
`ifdef FRAME_CNT_EN
    localparam int FC_EN = 1;
`else
    localparam int FC_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          ld_en;
    logic          dec_start;
    logic          pg_start;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic [IW-1:0] frame_id;
    logic          busy;
    logic [15:0]   frame_cnt;

    mimo_frame_sched #(.DEC_LAT(DL), .PG_LAT(PL), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ld_en     (ld_en),
        .dec_start (dec_start),
        .pg_start  (pg_start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .frame_id  (frame_id),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Observed events (written only by the compare process).
    int   ld_total = 0;
    int   ov_total = 0;
    int   ev_ld    = -1;
    int   ev_dec   = -1;
    int   ev_pg    = -1;
    int   ev_ov    = -1;
    logic prev_ov  = 1'b0;

    // Model state.
    bit m_busy = 1'b0;
    int m_acc  = 0;
    int m_id   = 0;
    int m_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] fc(input int n);
        return (FC_EN != 0) ? 32'(n) : 32'd0;
    endfunction

    // Per-cycle compare against the model, then advance the model.
    initial begin : cmp
        int   d;
        logic e_ir, e_ld, e_ds, e_ps, e_ov, e_bz, hs;
        forever begin
            @(negedge clk);
            e_ir = 1'b0; e_ld = 1'b0; e_ds = 1'b0; e_ps = 1'b0; e_ov = 1'b0; e_bz = 1'b0;
            if (!rst) begin
                m_busy = 1'b0;
                m_id   = 0;
                m_cnt  = 0;
            end else begin
                d    = cyc - m_acc;
                e_bz = m_busy;
                e_ds = m_busy && (d == 1);
                e_ps = m_busy && (d == 1 + DL);
                e_ov = m_busy && (d >= 1 + DL + PL);
                e_ir = flush ? 1'b0 : (!m_busy ? 1'b1 : (e_ov ? out_ready : 1'b0));
                e_ld = in_valid & e_ir;
            end
            check("in_ready",  32'(in_ready),  32'(e_ir));
            check("ld_en",     32'(ld_en),     32'(e_ld));
            check("dec_start", 32'(dec_start), 32'(e_ds));
            check("pg_start",  32'(pg_start),  32'(e_ps));
            check("out_valid", 32'(out_valid), 32'(e_ov));
            check("busy",      32'(busy),      32'(e_bz));
            check("frame_id",  32'(frame_id),  32'(m_id));
            check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));

            if (ld_en === 1'b1) begin ld_total++; ev_ld = cyc; end
            if (dec_start === 1'b1) ev_dec = cyc;
            if (pg_start === 1'b1) ev_pg = cyc;
            if (out_valid === 1'b1) begin
                ov_total++;
                if (!prev_ov) ev_ov = cyc;
            end
            prev_ov = (out_valid === 1'b1);

            if (rst) begin
                hs = e_ov && out_ready && !flush;
                if (hs && (FC_EN != 0) && (m_cnt < 65535)) m_cnt++;
                if (flush) begin
                    m_busy = 1'b0;
                end else if (e_ld) begin
                    m_busy = 1'b1;
                    m_acc  = cyc;
                    m_id   = (m_id + 1) % (1 << IW);
                end else if (hs) begin
                    m_busy = 1'b0;
                end
            end
            cyc++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c, l0, o0, p0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        tick(3);
        // A frame offered during reset must not be taken.
        in_valid = 1'b1; tick(1); in_valid = 1'b0;
        rst = 1'b1; tick(1);

        // Single frame.
        c = cyc; o0 = ov_total;
        in_valid = 1'b1; tick(1); in_valid = 1'b0; tick(15);
        check("t1_ld_at",  32'(ev_ld - c),  32'd0);
        check("t1_dec_at", 32'(ev_dec - c), 32'd1);
        check("t1_pg_at",  32'(ev_pg - c),  32'd7);
        check("t1_ov_at",  32'(ev_ov - c),  32'd11);
        check("t1_ov_len", 32'(ov_total - o0), 32'd1);
        check("t1_id",     32'(frame_id), 32'd1);
        check("t1_cnt",    32'(frame_cnt), fc(1));

        // Backpressure: 5 stalled cycles after out_valid rises.
        out_ready = 1'b0; c = cyc; o0 = ov_total;
        in_valid = 1'b1; tick(1); in_valid = 1'b0; tick(15);
        out_ready = 1'b1; tick(4);
        check("t2_ov_at",  32'(ev_ov - c), 32'd11);
        check("t2_ov_len", 32'(ov_total - o0), 32'd6);
        check("t2_id",     32'(frame_id), 32'd2);

        // Back-to-back stream of three frames.
        c = cyc; l0 = ld_total;
        in_valid = 1'b1; tick(23); in_valid = 1'b0; tick(15);
        check("t3_accepts", 32'(ld_total - l0), 32'd3);
        check("t3_last_ld", 32'(ev_ld - c), 32'd22);
        check("t3_id",      32'(frame_id), 32'd5);
        check("t3_cnt",     32'(frame_cnt), fc(5));

        // Flush in the third DEC cycle (counter at 3).
        c = cyc; p0 = ev_pg; o0 = ov_total;
        in_valid = 1'b1; tick(1); in_valid = 1'b0; tick(2);
        flush = 1'b1; tick(1); flush = 1'b0;
        check("t4_idle", 32'(busy), 32'd0);
        tick(12);
        check("t4_no_pg", 32'(ev_pg), 32'(p0));
        check("t4_no_ov", 32'(ov_total - o0), 32'd0);
        check("t4_id",    32'(frame_id), 32'd6);
        c = cyc; o0 = ov_total;
        in_valid = 1'b1; tick(1); in_valid = 1'b0; tick(15);
        check("t4_next_ov", 32'(ev_ov - c), 32'd11);
        check("t4_next_n",  32'(ov_total - o0), 32'd1);
        check("t4_cnt",     32'(frame_cnt), fc(6));

        // Flush while a result is stalled, with a competing in_valid.
        out_ready = 1'b0; l0 = ld_total; o0 = ov_total;
        in_valid = 1'b1; tick(1); in_valid = 1'b0; tick(11);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; tick(1);
        flush = 1'b0; in_valid = 1'b0; tick(3);
        check("t5_accepts", 32'(ld_total - l0), 32'd1);
        check("t5_ov_len",  32'(ov_total - o0), 32'd2);
        check("t5_id",      32'(frame_id), 32'd8);
        check("t5_cnt",     32'(frame_cnt), fc(6));

        // Asynchronous reset in the middle of PG.
        c = cyc;
        in_valid = 1'b1; tick(1); in_valid = 1'b0; tick(7);
        check("t6_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_busy",     32'(busy), 32'd0);
        check("t6_id",       32'(frame_id), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        check("t6_pg",       32'(pg_start), 32'd0);
        check("t6_cnt",      32'(frame_cnt), 32'd0);
        tick(2);
        rst = 1'b1; o0 = ov_total;
        tick(15);
        check("t6_no_ov", 32'(ov_total - o0), 32'd0);

        // 256 back-to-back frames wrap the tag.
        l0 = ld_total;
        in_valid = 1'b1; tick(1 + 255 * 11); in_valid = 1'b0; tick(15);
        check("t7_accepts", 32'(ld_total - l0), 32'd256);
        check("t7_id",      32'(frame_id), 32'd0);
        check("t7_cnt",     32'(frame_cnt), fc(256));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mimo_frame_sched.md
MIMO_FRAME_SCHED -- requirements
Module: mimo_frame_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports named clk and rst.
REQ-002 Parameter DEC_LAT, default 6: QR decomposition latency in cycles, from dec_start to a valid Rmat/Yarr/colorder; legal range 1..63.
REQ-003 Parameter PG_LAT, default 4: path generator latency in cycles, from pg_start to a valid PATH/PED; legal range 1..63.
REQ-004 Parameter ID_W, default 8: width of the frame tag.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, async reset, active low.
- in_valid, in, 1, H/Y frame present.
- in_ready, out, 1, frame accepted when in_valid is also high.
- ld_en, out, 1, H/Y input-register capture strobe.
- dec_start, out, 1, decomposition start pulse.
- pg_start, out, 1, path generator start pulse.
- out_valid, out, 1, PATH/PED result ready.
- out_ready, in, 1, downstream accepts the result.
- flush, in, 1, synchronous abort.
- frame_id, out, ID_W, tag of the current frame.
- busy, out, 1, high in any state other than IDLE.
- frame_cnt, out, 16, count of completed frames.

Function
REQ-006 The FSM SHALL have the states IDLE, DEC, PG and OUT.
REQ-007 In IDLE, in_ready SHALL be 1. ld_en SHALL equal in_valid&in_ready, combinationally. An accept SHALL move the FSM to DEC on the next cycle.
REQ-008 dec_start SHALL pulse for exactly the first DEC cycle. The FSM SHALL remain in DEC for DEC_LAT cycles, using a 6-bit down-counter, and then enter PG.
REQ-009 pg_start SHALL pulse for exactly the first PG cycle. The FSM SHALL remain in PG for PG_LAT cycles and then enter OUT.
REQ-010 Latency: for an accept at edge T:
- dec_start SHALL be high in cycle T+1.
- pg_start SHALL be high in cycle T+1+DEC_LAT.
- out_valid SHALL first be high in cycle T+1+DEC_LAT+PG_LAT.
REQ-011 In OUT, out_valid SHALL be held high until out_ready is sampled high. No other output SHALL change while out_valid is stalled.
REQ-012 Overlap: in OUT, in_ready SHALL equal out_ready.
- An out handshake with in_valid high SHALL accept the new frame (ld_en high) and go directly to DEC.
- An out handshake without in_valid SHALL go to IDLE.
REQ-013 in_ready SHALL be 0 in DEC and PG.
REQ-014 frame_id SHALL increment by 1 on every accept and wrap from 2^ID_W-1 to 0. A frame SHALL hold its frame_id until that frame's out handshake.
REQ-015 flush SHALL take priority over every other input. From any state, flush SHALL cause the following on the next edge:
- The FSM goes to IDLE.
- The counter clears.
- out_valid is not issued.
- frame_id and frame_cnt are unchanged.
- in_ready is 0 and ld_en is 0 during the flush cycle.
REQ-016 dec_start and pg_start SHALL never be high in the same cycle. dec_start and ld_en SHALL never be high in the same cycle.
REQ-017 busy SHALL be registered-state derived (state != IDLE).

Reset
REQ-018 While rst=0, the following SHALL hold:
- state=IDLE, counter=0, frame_id=0, frame_cnt=0.
- dec_start, pg_start, out_valid and busy are 0.
- in_ready=0 and ld_en=0.
REQ-019 Reset assertion SHALL take effect asynchronously. Deassertion SHALL take effect at the next clk edge. A frame in flight during reset SHALL be discarded without out_valid.

Configuration
REQ-020 Macro FRAME_CNT_EN: when defined, frame_cnt SHALL increment on each out handshake and saturate at 16'hFFFF.
REQ-021 When FRAME_CNT_EN is undefined, frame_cnt SHALL be constant 0 and no counter register SHALL be synthesized.

Verification (DEC_LAT=6, PG_LAT=4, ID_W=8)
REQ-022 Single frame: in_valid pulsed at cycle 0 with out_ready=1 -> ld_en high at 0, dec_start high at 1, pg_start high at 7, out_valid high at 11 for 1 cycle, frame_id=1, frame_cnt=1.
REQ-023 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid held for 6 cycles, in_ready=0, frame_id stable.
REQ-024 Back-to-back: in_valid held high with out_ready=1 -> frames accepted every 11 cycles, each accept coinciding with the out handshake, frame_id incrementing 1,2,3.
REQ-025 Flush during DEC counter=3 -> FSM in IDLE on the next cycle, no pg_start, no out_valid, frame_cnt unchanged, next frame fully processed.
REQ-026 Wrap/reset: 256 frames -> frame_id wraps to 0. rst=0 mid-PG -> all outputs 0 asynchronously and no out_valid after release.
REQ-027 Build with and without FRAME_CNT_EN -> frame_cnt equals the number of frames completed, or stays 0, respectively.
